timer_apb_regs: RTL

APB-style register front end that sits directly upstream of the 8-bit timer core on pclk.
- Decodes APB reads and writes into the timer control signals: reg_tdr, load, en, up_down and cks.
- Captures the timer's single-cycle ovf/udf pulses into sticky status flags.
- Drives a maskable interrupt.

---
 rtl/timer_pkg.sv | 31 +++
 rtl/timer_apb_regs_if.sv | 25 ++
 rtl/timer_apb_if.sv | 97 +++++++++
 rtl/timer_apb_regs.sv | 128 ++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the timer APB register front end: address map,
// register bit positions and the APB handshake state encoding.
package timer_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned WAIT_W = 3;

    localparam int unsigned ADDR_TDR  = 0;
    localparam int unsigned ADDR_TCR  = 1;
    localparam int unsigned ADDR_TSR  = 2;
    localparam int unsigned ADDR_TIER = 3;

    localparam int unsigned TCR_LOAD   = 7;
    localparam int unsigned TCR_UPDN   = 5;
    localparam int unsigned TCR_EN     = 4;
    localparam int unsigned TCR_CKS_HI = 1;
    localparam int unsigned TCR_CKS_LO = 0;

    localparam int unsigned TSR_OVF = 0;
    localparam int unsigned TSR_UDF = 1;

    localparam int unsigned TIER_OVFIE = 0;
    localparam int unsigned TIER_UDFIE = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

endpackage

// File: rtl/timer_apb_regs_if.sv
// APB completer-side bus bundle for the timer register block.
interface timer_apb_regs_if
    import timer_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_apb_if.sv
// APB handshake engine: phase tracking, wait-state counter and registered
// pready/pslverr; hands write/read strobes to the register bank.
module timer_apb_if
    import timer_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    output logic              pready,
    output logic              pslverr,
    output logic              wr_stb,
    output logic              rd_stb,
    output logic [ADDR_W-1:0] addr
);

    localparam int unsigned CNT_W = WAIT_W + 1;

    apb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              last_wait;
    logic              bad_addr;

    assign cnt_inc   = {1'b0, cnt_q} + CNT_W'(1);
    assign last_wait = (cnt_inc == CNT_W'(WAIT_CYCLES));
    assign bad_addr  = (paddr > ADDR_W'(ADDR_TIER));

    // State records the phase sampled at the last edge: SETUP means a setup
    // phase was seen, so the current cycle is the first ACCESS cycle.
    // pready is decided one edge early so it can be a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        rd_stb    = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d  = SETUP;
                    cnt_d    = '0;
                    pready_d = (WAIT_CYCLES == 0);
                end
            end
            SETUP, ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (pready_q) begin
                    // completing now; a back-to-back setup is picked up from IDLE
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (penable) begin
                    state_d  = ACCESS;
                    cnt_d    = cnt_inc[WAIT_W-1:0];
                    pready_d = last_wait;
                end else begin
                    state_d  = SETUP;
                    cnt_d    = '0;
                    pready_d = (WAIT_CYCLES == 0);
                end
            end
            default: state_d = IDLE;
        endcase
        pslverr_d = pready_d & bad_addr;
        // read data is captured on the edge that raises pready
        rd_stb    = pready_d & !pwrite;
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign wr_stb  = psel & penable & pready_q & pwrite;
    assign addr    = paddr;

endmodule

// File: rtl/timer_apb_regs.sv
// Timer register bank behind an APB completer: TDR/TCR/TSR/TIER, load pulse,
// sticky overflow/underflow flags and a maskable interrupt.
module timer_apb_regs
    import timer_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic                   pclk,
    input  logic                   presetn,
    timer_apb_regs_if.slave        apb,
    input  logic                   tmr_ovf,
    input  logic                   tmr_udf,
    output logic [DATA_W-1:0]      reg_tdr,
    output logic                   load,
    output logic                   en,
    output logic                   up_down,
    output logic [1:0]             cks,
    output logic                   irq
);

    logic              wr_stb;
    logic              rd_stb;
    logic [ADDR_W-1:0] addr;

    logic              wr_tdr, wr_tcr, wr_tsr, wr_tier;
    logic [DATA_W-1:0] tdr_q, tdr_d;
    logic              en_q, en_d;
    logic              updn_q, updn_d;
    logic [1:0]        cks_q, cks_d;
    logic              load_q, load_d;
    logic [1:0]        tsr_q, tsr_d;
    logic [1:0]        tier_q, tier_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [DATA_W-1:0] rd_mux;

    timer_apb_if #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .ADDR_W      (ADDR_W)
    ) u_apb (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (apb.psel),
        .penable (apb.penable),
        .pwrite  (apb.pwrite),
        .paddr   (apb.paddr),
        .pready  (apb.pready),
        .pslverr (apb.pslverr),
        .wr_stb  (wr_stb),
        .rd_stb  (rd_stb),
        .addr    (addr)
    );

    // Register next-state, W1C status and read mux
    always_comb begin
        wr_tdr  = wr_stb && (addr == ADDR_W'(ADDR_TDR));
        wr_tcr  = wr_stb && (addr == ADDR_W'(ADDR_TCR));
        wr_tsr  = wr_stb && (addr == ADDR_W'(ADDR_TSR));
        wr_tier = wr_stb && (addr == ADDR_W'(ADDR_TIER));

        tdr_d  = tdr_q;
        en_d   = en_q;
        updn_d = updn_q;
        cks_d  = cks_q;
        tier_d = tier_q;
        tsr_d  = tsr_q;

        if (wr_tdr) tdr_d = apb.pwdata;
        if (wr_tcr) begin
            en_d   = apb.pwdata[TCR_EN];
            updn_d = apb.pwdata[TCR_UPDN];
            cks_d  = apb.pwdata[TCR_CKS_HI:TCR_CKS_LO];
        end
        if (wr_tier) tier_d = {apb.pwdata[TIER_UDFIE], apb.pwdata[TIER_OVFIE]};
        load_d = wr_tcr & apb.pwdata[TCR_LOAD];

        // clear first so a coincident hardware event wins
        if (wr_tsr) tsr_d = tsr_q & ~{apb.pwdata[TSR_UDF], apb.pwdata[TSR_OVF]};
        tsr_d[TSR_OVF] = tsr_d[TSR_OVF] | tmr_ovf;
        tsr_d[TSR_UDF] = tsr_d[TSR_UDF] | tmr_udf;

        irq_d = |(tsr_q & tier_q);

        rd_mux = '0;
        case (addr)
            ADDR_W'(ADDR_TDR):  rd_mux = tdr_q;
            ADDR_W'(ADDR_TCR):  rd_mux = {2'b00, updn_q, en_q, 2'b00, cks_q};
            ADDR_W'(ADDR_TSR):  rd_mux = {6'd0, tsr_q};
            ADDR_W'(ADDR_TIER): rd_mux = {6'd0, tier_q};
            default:            rd_mux = '0;
        endcase
        prdata_d = rd_stb ? rd_mux : '0;
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            tdr_q    <= '0;
            en_q     <= 1'b0;
            updn_q   <= 1'b0;
            cks_q    <= '0;
            load_q   <= 1'b0;
            tsr_q    <= '0;
            tier_q   <= '0;
            irq_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            tdr_q    <= tdr_d;
            en_q     <= en_d;
            updn_q   <= updn_d;
            cks_q    <= cks_d;
            load_q   <= load_d;
            tsr_q    <= tsr_d;
            tier_q   <= tier_d;
            irq_q    <= irq_d;
            prdata_q <= prdata_d;
        end
    end

    assign apb.prdata = prdata_q;
    assign reg_tdr    = tdr_q;
    assign load       = load_q;
    assign en         = en_q;
    assign up_down    = updn_q;
    assign cks        = cks_q;
    assign irq        = irq_q;

endmodule
